// File: rtl/jtag_uart_av_pkg.sv
// Shared register map, bit positions and FSM encoding for the JTAG UART
// Avalon-MM master.
package jtag_uart_av_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int unsigned RVALID_BIT = 15;

  // WSPACE lives in CONTROL, RAVAIL lives in DATA; both are the upper halfword
  localparam int unsigned WSPACE_MSB = 31;
  localparam int unsigned WSPACE_LSB = 16;
  localparam int unsigned RAVAIL_MSB = 31;
  localparam int unsigned RAVAIL_LSB = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_CTRL,
    RD_DATA
  } state_t;

endpackage

// File: rtl/jua_sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// Push while full and pop while empty are ignored.
module jua_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/jtag_uart_av_master.sv
// Avalon-MM master that feeds TX bytes into a JTAG UART data register when
// WSPACE allows, and polls the same register for RX bytes.
module jtag_uart_av_master
  import jtag_uart_av_pkg::*;
#(
  parameter int unsigned TX_DEPTH    = 16,
  parameter int unsigned POLL_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_data,
  output logic                        tx_ready,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic                        av_chipselect,
  output logic                        av_address,
  output logic                        av_read_n,
  output logic                        av_write_n,
  output logic [31:0]                 av_writedata,
  input  logic [31:0]                 av_readdata,
  input  logic                        av_waitrequest
);

  localparam int unsigned PW = $clog2(POLL_CYCLES) + 1;
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);

  state_t        state_q, state_d;
  logic [15:0]   wspace_q, wspace_d;
  logic [15:0]   ravail_q, ravail_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          cs_q, cs_d;
  logic          addr_q, addr_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0]    fifo_dout;
  logic          unused_readdata;

  assign unused_readdata = ^av_readdata[14:8];

  assign tx_ready  = !fifo_full && !reset;
  assign fifo_push = tx_valid && tx_ready;

  jua_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (tx_level)
  );

  always_comb begin
    state_d    = state_q;
    wspace_d   = wspace_q;
    ravail_d   = ravail_q;
    poll_d     = poll_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    wdata_d    = wdata_q;
    fifo_pop   = 1'b0;

    // Consumer handshake first so a same-cycle load below overrides the clear
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty && wspace_q != '0) begin
          state_d = WR_DATA;
          wdata_d = {24'b0, fifo_dout};
        end else if (!fifo_empty && poll_q == '0) begin
          state_d = RD_CTRL;
        end else if (!rx_valid_q && (ravail_q != '0 || poll_q == '0)) begin
          state_d = RD_DATA;
        end else if (poll_q != '0) begin
          poll_d = poll_q - PW'(1);
        end
      end
      WR_DATA: begin
        if (!av_waitrequest) begin
          fifo_pop = 1'b1;
          wspace_d = wspace_q - 16'd1;
          state_d  = IDLE;
        end
      end
      RD_CTRL: begin
        if (!av_waitrequest) begin
          wspace_d = av_readdata[WSPACE_MSB:WSPACE_LSB];
          poll_d   = POLL_RELOAD;
          state_d  = IDLE;
        end
      end
      RD_DATA: begin
        if (!av_waitrequest) begin
          if (av_readdata[RVALID_BIT]) begin
            rx_data_d  = av_readdata[7:0];
            rx_valid_d = 1'b1;
            ravail_d   = av_readdata[RAVAIL_MSB:RAVAIL_LSB];
          end else begin
            ravail_d = '0;
            poll_d   = POLL_RELOAD;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus strobes are registered copies of the next state, so they drop on
    // the edge after completion and hold steady while stalled.
    cs_d   = (state_d != IDLE);
    addr_d = (state_d == RD_CTRL) ? ADDR_CTRL : ADDR_DATA;
    rd_n_d = !((state_d == RD_CTRL) || (state_d == RD_DATA));
    wr_n_d = (state_d != WR_DATA);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wspace_q   <= '0;
      ravail_q   <= '0;
      poll_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cs_q       <= 1'b0;
      addr_q     <= ADDR_DATA;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wspace_q   <= wspace_d;
      ravail_q   <= ravail_d;
      poll_q     <= poll_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      wdata_q    <= wdata_d;
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign av_chipselect = cs_q;
  assign av_address    = addr_q;
  assign av_read_n     = rd_n_q;
  assign av_write_n    = wr_n_q;
  assign av_writedata  = wdata_q;

endmodule
